// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's control inputs, instruction-memory bus and IF/ID outputs.
// The master modport is the fetch stage; the slave side is the hazard unit, memory and decode.
interface fetch_stage_if;
   logic        StallF;
   logic        StallD;
   logic        FlushD;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        HaltReq;
   logic [31:0] RD;
   logic [31:0] A;
   logic [31:0] PCF;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        ValidD;
   logic        Halted;
   logic        FetchFault;
   logic [31:0] FetchCount;

   modport master (
      input  StallF, StallD, FlushD, PCSrcE, PCTargetE, HaltReq, RD,
      output A, PCF, InstrD, PCD, PCPlus4D, ValidD, Halted, FetchFault, FetchCount
   );

   modport slave (
      output StallF, StallD, FlushD, PCSrcE, PCTargetE, HaltReq, RD,
      input  A, PCF, InstrD, PCD, PCPlus4D, ValidD, Halted, FetchFault, FetchCount
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, BOOT/RUN/HALT control and the IF/ID pipeline register.
// The memory word index is combinational from PCF, so the fetched word arrives in the same cycle.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MEM_DEPTH = 64,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input logic          CLK,
   input logic          Reset,
   fetch_stage_if.master bus
);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   state_t      r_state;
   logic [31:0] r_pcF;
   logic [31:0] r_instrD;
   logic [31:0] r_pcD;
   logic [31:0] r_pcPlus4D;
   logic        r_validD;
   logic        r_halted;
   logic        r_fault;
   logic [31:0] r_count;

   logic [31:0] w_pcPlus4;
   logic [31:0] w_target;
   logic [31:0] w_wordIdx;
   logic        w_outOfRange;

   assign w_pcPlus4    = r_pcF + 32'd4;
   assign w_target     = {bus.PCTargetE[31:2], 2'b00};
   assign w_wordIdx    = {2'b00, r_pcF[31:2]};
   assign w_outOfRange = (w_wordIdx >= $unsigned(MEM_DEPTH));

   // A halt request that coincides with a redirect belongs to a wrong-path instruction, so it is ignored.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state    <= BOOT;
         r_pcF      <= RESET_PC;
         r_instrD   <= NOP_INSTR;
         r_pcD      <= 32'd0;
         r_pcPlus4D <= 32'd0;
         r_validD   <= 1'b0;
         r_halted   <= 1'b0;
         r_fault    <= 1'b0;
         r_count    <= 32'd0;
      end else begin
         case (r_state)
            BOOT: begin
               r_state    <= RUN;
               r_instrD   <= NOP_INSTR;
               r_pcD      <= 32'd0;
               r_pcPlus4D <= 32'd0;
               r_validD   <= 1'b0;
            end
            RUN: begin
               if (bus.HaltReq && !bus.PCSrcE) begin
                  r_state    <= HALT;
                  r_halted   <= 1'b1;
                  r_instrD   <= NOP_INSTR;
                  r_pcD      <= 32'd0;
                  r_pcPlus4D <= 32'd0;
                  r_validD   <= 1'b0;
               end else begin
                  if (bus.PCSrcE) begin
                     r_pcF <= w_target;
                  end else if (!bus.StallF) begin
                     r_pcF <= w_pcPlus4;
                  end

                  // Flush and redirect both squash ID, even when decode asked to stall.
                  if (bus.FlushD || bus.PCSrcE) begin
                     r_instrD   <= NOP_INSTR;
                     r_pcD      <= 32'd0;
                     r_pcPlus4D <= 32'd0;
                     r_validD   <= 1'b0;
                  end else if (!bus.StallD) begin
                     if (w_outOfRange) begin
                        r_instrD   <= NOP_INSTR;
                        r_pcD      <= 32'd0;
                        r_pcPlus4D <= 32'd0;
                        r_validD   <= 1'b0;
                        r_fault    <= 1'b1;
                     end else begin
                        r_instrD   <= bus.RD;
                        r_pcD      <= r_pcF;
                        r_pcPlus4D <= w_pcPlus4;
                        r_validD   <= 1'b1;
                        r_count    <= r_count + 32'd1;
                     end
                  end
               end
            end
            HALT: begin
               r_halted   <= 1'b1;
               r_instrD   <= NOP_INSTR;
               r_pcD      <= 32'd0;
               r_pcPlus4D <= 32'd0;
               r_validD   <= 1'b0;
            end
            default: begin
               r_state <= BOOT;
            end
         endcase
      end
   end

   assign bus.A          = w_wordIdx;
   assign bus.PCF        = r_pcF;
   assign bus.InstrD     = r_instrD;
   assign bus.PCD        = r_pcD;
   assign bus.PCPlus4D   = r_pcPlus4D;
   assign bus.ValidD     = r_validD;
   assign bus.Halted     = r_halted;
   assign bus.FetchFault = r_fault;
   assign bus.FetchCount = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a table of per-cycle inputs and hand-derived expected
// IF/ID state, queued on drive and compared one cycle later, plus halt and reset sequences.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   localparam logic [5:0] C_NONE = 6'b000000;
   localparam logic [5:0] C_RST  = 6'b100000;
   localparam logic [5:0] C_SF   = 6'b010000;
   localparam logic [5:0] C_SD   = 6'b001000;
   localparam logic [5:0] C_FD   = 6'b000100;
   localparam logic [5:0] C_PS   = 6'b000010;
   localparam logic [5:0] C_HR   = 6'b000001;

   typedef struct packed {
      logic [5:0]  ctrl;
      logic [31:0] tgt;
      logic [31:0] pcf;
      logic [31:0] instrD;
      logic [31:0] pcD;
      logic [31:0] pcPlus4D;
      logic        validD;
      logic        halted;
      logic        fault;
      logic [31:0] count;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   logic [31:0] mem [0:63];
   vec_t vecs[$];
   vec_t scoreboard[$];
   int checks = 0;
   int errors = 0;
   int rowNum = 0;

   always #5 clk = ~clk;

   fetch_stage_if bus();

   fetch_stage #(
      .RESET_PC (32'h0000_0000),
      .MEM_DEPTH(64),
      .NOP_INSTR(NOP)
   ) dut (
      .CLK  (clk),
      .Reset(reset),
      .bus  (bus.master)
   );

   assign bus.RD = (bus.A < 32'd64) ? mem[bus.A[5:0]] : 32'hDEAD_BEEF;

   function automatic logic [31:0] memWord(input logic [31:0] idx);
      case (idx)
         32'd0:   return 32'h0050_0093;
         32'd1:   return 32'h0010_0113;
         32'd2:   return 32'h0020_81B3;
         32'd3:   return 32'h0000_0013;
         default: return 32'hA000_0000 + idx;
      endcase
   endfunction

   function automatic vec_t mk(input logic [5:0] c, input logic [31:0] t, input logic [31:0] pcf,
                               input logic [31:0] instr, input logic [31:0] pcd, input logic [31:0] p4,
                               input logic vld, input logic hl, input logic flt, input logic [31:0] cnt);
      vec_t v;
      v.ctrl = c; v.tgt = t; v.pcf = pcf; v.instrD = instr; v.pcD = pcd; v.pcPlus4D = p4;
      v.validD = vld; v.halted = hl; v.fault = flt; v.count = cnt;
      return v;
   endfunction

   // Expected ID holds the bubble.
   function automatic vec_t bub(input logic [5:0] c, input logic [31:0] t, input logic [31:0] pcf,
                                input logic hl, input logic flt, input logic [31:0] cnt);
      return mk(c, t, pcf, NOP, 32'd0, 32'd0, 1'b0, hl, flt, cnt);
   endfunction

   // Expected ID holds the real instruction fetched from byte address pcd.
   function automatic vec_t ld(input logic [5:0] c, input logic [31:0] t, input logic [31:0] pcf,
                               input logic [31:0] pcd, input logic [31:0] cnt, input logic flt);
      return mk(c, t, pcf, memWord(pcd >> 2), pcd, pcd + 32'd4, 1'b1, 1'b0, flt, cnt);
   endfunction

   task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      reset         = v.ctrl[5];
      bus.StallF    = v.ctrl[4];
      bus.StallD    = v.ctrl[3];
      bus.FlushD    = v.ctrl[2];
      bus.PCSrcE    = v.ctrl[1];
      bus.HaltReq   = v.ctrl[0];
      bus.PCTargetE = v.tgt;
      scoreboard.push_back(v);
   endtask

   task automatic checkOutput();
      vec_t e;
      @(posedge clk);
      #1;
      if (scoreboard.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL row%0d scoreboard: got empty expected entry", rowNum);
      end else begin
         e = scoreboard.pop_front();
         checkField($sformatf("row%0d PCF", rowNum), bus.PCF, e.pcf);
         checkField($sformatf("row%0d A", rowNum), bus.A, {2'b00, e.pcf[31:2]});
         checkField($sformatf("row%0d InstrD", rowNum), bus.InstrD, e.instrD);
         checkField($sformatf("row%0d PCD", rowNum), bus.PCD, e.pcD);
         checkField($sformatf("row%0d PCPlus4D", rowNum), bus.PCPlus4D, e.pcPlus4D);
         checkField($sformatf("row%0d ValidD", rowNum), {31'd0, bus.ValidD}, {31'd0, e.validD});
         checkField($sformatf("row%0d Halted", rowNum), {31'd0, bus.Halted}, {31'd0, e.halted});
         checkField($sformatf("row%0d FetchFault", rowNum), {31'd0, bus.FetchFault}, {31'd0, e.fault});
         checkField($sformatf("row%0d FetchCount", rowNum), bus.FetchCount, e.count);
      end
      rowNum++;
   endtask

   task automatic runRow(input vec_t v);
      applyStimulus(v);
      checkOutput();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = memWord(32'(i));
      reset         = 1'b1;
      bus.StallF    = 1'b0;
      bus.StallD    = 1'b0;
      bus.FlushD    = 1'b0;
      bus.PCSrcE    = 1'b0;
      bus.HaltReq   = 1'b0;
      bus.PCTargetE = 32'd0;

      vecs.push_back(bub(C_RST, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0));
      vecs.push_back(bub(C_NONE, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0));
      vecs.push_back(ld(C_NONE, 32'd0, 32'd4, 32'd0, 32'd1, 1'b0));
      vecs.push_back(ld(C_NONE, 32'd0, 32'd8, 32'd4, 32'd2, 1'b0));
      vecs.push_back(ld(C_SF | C_SD, 32'd0, 32'd8, 32'd4, 32'd2, 1'b0));
      vecs.push_back(ld(C_SF | C_SD, 32'd0, 32'd8, 32'd4, 32'd2, 1'b0));
      vecs.push_back(ld(C_NONE, 32'd0, 32'd12, 32'd8, 32'd3, 1'b0));
      vecs.push_back(ld(C_NONE, 32'd0, 32'd16, 32'd12, 32'd4, 1'b0));
      vecs.push_back(bub(C_PS | C_SF | C_SD, 32'h20, 32'h20, 1'b0, 1'b0, 32'd4));
      vecs.push_back(ld(C_NONE, 32'd0, 32'h24, 32'h20, 32'd5, 1'b0));
      vecs.push_back(bub(C_FD | C_SD, 32'd0, 32'h28, 1'b0, 1'b0, 32'd5));
      vecs.push_back(bub(C_PS | C_HR, 32'h103, 32'h100, 1'b0, 1'b0, 32'd5));
      vecs.push_back(bub(C_NONE, 32'd0, 32'h104, 1'b0, 1'b1, 32'd5));
      vecs.push_back(bub(C_PS, 32'd0, 32'd0, 1'b0, 1'b1, 32'd5));
      vecs.push_back(ld(C_NONE, 32'd0, 32'd4, 32'd0, 32'd6, 1'b1));

      for (int i = 0; i < vecs.size(); i++) runRow(vecs[i]);

      $display("[TB] halt sequence");
      runRow(bub(C_HR, 32'd0, 32'd4, 1'b1, 1'b1, 32'd6));
      for (int i = 0; i < 10; i++) begin
         if (i % 3 == 0) runRow(bub(C_PS | C_SF, 32'h40, 32'd4, 1'b1, 1'b1, 32'd6));
         else            runRow(bub(C_NONE, 32'd0, 32'd4, 1'b1, 1'b1, 32'd6));
      end

      $display("[TB] reset recovery and mid-run reset sequence");
      runRow(bub(C_RST, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0));
      runRow(bub(C_NONE, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0));
      runRow(ld(C_NONE, 32'd0, 32'd4, 32'd0, 32'd1, 1'b0));
      runRow(bub(C_PS, 32'h100, 32'h100, 1'b0, 1'b0, 32'd1));
      runRow(bub(C_NONE, 32'd0, 32'h104, 1'b0, 1'b1, 32'd1));
      runRow(bub(C_PS, 32'h1C, 32'h1C, 1'b0, 1'b1, 32'd1));
      runRow(bub(C_RST, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0));
      runRow(bub(C_NONE, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0));
      runRow(ld(C_NONE, 32'd0, 32'd4, 32'd0, 32'd1, 1'b0));

      $display("[TB] PC wrap sequence");
      runRow(bub(C_PS, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd1));
      runRow(bub(C_NONE, 32'd0, 32'd0, 1'b0, 1'b1, 32'd1));
      runRow(ld(C_NONE, 32'd0, 32'd4, 32'd0, 32'd2, 1'b1));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
